// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit common-anode seven-segment driver
// with double-buffered frames, leading-zero blanking and a ghost-blank cycle per slot.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);
  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_dig, r_act_dig;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic                    r_frame_pend;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    w_wrap, w_last, w_frame, w_lz;
  logic [3:0]              w_nib;
  logic [6:0]              w_glyph;
  assign w_wrap  = r_tick == TW'(REFRESH_DIV - 1);
  assign w_last  = r_idx == IW'(NUM_DIGITS - 1);
  assign w_frame = w_wrap && w_last;
  assign w_nib   = r_act_dig[{r_idx, 2'b00} +: 4];
  // a digit is a leading zero when it and every more-significant digit are zero
  assign w_lz    = blank_lz && r_idx != '0 && (r_act_dig >> {r_idx, 2'b00}) == '0;
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_nib)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = HEX_MODE != 0 ? 7'b0001000 : 7'b1111111;
      4'hB: w_glyph = HEX_MODE != 0 ? 7'b0000011 : 7'b1111111;
      4'hC: w_glyph = HEX_MODE != 0 ? 7'b1000110 : 7'b1111111;
      4'hD: w_glyph = HEX_MODE != 0 ? 7'b0100001 : 7'b1111111;
      4'hE: w_glyph = HEX_MODE != 0 ? 7'b0000110 : 7'b1111111;
      default: w_glyph = HEX_MODE != 0 ? 7'b0001110 : 7'b1111111;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
      r_frame_pend <= 1'b0;
      r_an         <= '1;
      r_seg        <= '1;
      r_dp         <= 1'b1;
    end else begin
      r_tick <= w_wrap ? '0 : r_tick + TW'(1);
      if (w_wrap) r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_dp  <= dp_in;
      end
      // a load landing on the frame boundary stays pending for the following frame
      if (w_frame && r_frame_pend) begin
        r_act_dig <= r_pend_dig;
        r_act_dp  <= r_pend_dp;
      end
      r_frame_pend <= load || (r_frame_pend && !w_frame);
      r_an  <= (!en || r_tick == '0) ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= (!en || w_lz) ? '1 : w_glyph;
      r_dp  <= !en || !r_act_dp[r_idx];
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: table vectors, hand sequences and a time-based reference model
// for a 4-digit, 4-cycle-slot display in both hex and decimal-only builds.
module tb_seven_seg_scan_driver;
  logic        clk, rst, load, blank_lz, en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0;
  int checks = 0, errors = 0, t = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) u1 (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .en(en), .an(an1), .seg(seg1), .dp(dp1));
  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) u0 (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .en(en), .an(an0), .seg(seg0), .dp(dp0));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  typedef struct {int t; logic [15:0] d; logic [3:0] p;} ld_t;
  ld_t q[$];
  logic [3:0] exp_an;
  logic [6:0] exp_s1, exp_s0;
  logic       exp_dp;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, a, e, t);
    end
  endtask

  // Model: cycle c belongs to slot c/4 and frame c/16; a frame shows the last
  // load taken at least two cycles before the frame's first cycle.
  always @(posedge clk) begin : mdl
    int f, ix, ph;
    logic [15:0] fd;
    logic [3:0] fp, nib;
    logic lz;
    if (rst) begin
      t = 0;
      q.delete();
    end else begin
      if (load) q.push_back('{t, digits_in, dp_in});
      f = (t / 16) * 16;
      fd = 0;
      fp = 0;
      foreach (q[i]) if (q[i].t <= f - 2) begin fd = q[i].d; fp = q[i].p; end
      ix = (t / 4) % 4;
      ph = t % 4;
      nib = fd[4*ix +: 4];
      lz = blank_lz && ix != 0 && (fd >> (4 * ix)) == 0;
      exp_an = (!en || ph == 0) ? 4'hF : ~(4'b0001 << ix);
      exp_s1 = (!en || lz) ? 7'h7F : glyph[nib];
      exp_s0 = (!en || lz || nib > 9) ? 7'h7F : glyph[nib];
      exp_dp = !en || !fp[ix];
      t++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_an", an1, 4'hF);
      chk("rst_seg", seg1, 7'h7F);
      chk("rst_dp", dp1, 1'b1);
    end else if (t > 0) begin
      chk("mdl_an", an1, exp_an);
      chk("mdl_an_h0", an0, exp_an);
      chk("mdl_seg_hex", seg1, exp_s1);
      chk("mdl_seg_dec", seg0, exp_s0);
      chk("mdl_dp", dp1, exp_dp);
    end
  end

  task automatic at_state(input int m);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (t > 0 && (t - 1) % 16 == m) return;
    end
    chk("state_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1;
    digits_in = d;
    dp_in = p;
    @(negedge clk);
    load = 0;
  endtask

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic        b;
    logic [27:0] s1;
    logic [27:0] s0;
    logic [3:0]  dpo;
  } vec_t;
  vec_t tv [7];

  initial begin
    int seen;
    logic [3:0] a;
    tv[0] = '{16'h1234, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
    tv[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000},
              {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1111};
    tv[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
              {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    tv[3] = '{16'h0000, 4'b0000, 1'b0, {4{7'b1000000}}, {4{7'b1000000}}, 4'b1111};
    tv[4] = '{16'hABCF, 4'b0000, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110},
              {4{7'h7F}}, 4'b1111};
    tv[5] = '{16'h0509, 4'b1000, 1'b1, {7'h7F, 7'b0010010, 7'b1000000, 7'b0010000},
              {7'h7F, 7'b0010010, 7'b1000000, 7'b0010000}, 4'b0111};
    tv[6] = '{16'h00E0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'b0000110, 7'b1000000},
              {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    rst = 1; load = 0; en = 1; blank_lz = 0; digits_in = 0; dp_in = 0;
    #1 chk("reset_an", an1, 4'hF);
    chk("reset_seg", seg1, 7'h7F);
    repeat (3) @(negedge clk);
    rst = 0;
    at_state(0);  chk("rel_ghost", an1, 4'hF);
    at_state(1);  chk("rel_an0", an1, 4'b1110); chk("rel_seg0", seg1, 7'b1000000);
    at_state(5);  chk("rel_an1", an1, 4'b1101);
    at_state(9);  chk("rel_an2", an1, 4'b1011);
    at_state(13); chk("rel_an3", an1, 4'b0111);
    for (int i = 0; i < 7; i++) begin
      blank_lz = tv[i].b;
      do_load(tv[i].d, tv[i].p);
      repeat (40) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        at_state(4 * d + 2);
        a = ~(4'b0001 << d);
        chk($sformatf("tv%0d_an%0d", i, d), an1, a);
        chk($sformatf("tv%0d_hex%0d", i, d), seg1, tv[i].s1[7*d +: 7]);
        chk($sformatf("tv%0d_dec%0d", i, d), seg0, tv[i].s0[7*d +: 7]);
        chk($sformatf("tv%0d_dp%0d", i, d), dp1, tv[i].dpo[d]);
      end
    end
    blank_lz = 0;
    do_load(16'h0003, 4'b0000);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 20 && t % 16 != 15; k++) @(negedge clk);
    do_load(16'h0008, 4'b0000);
    at_state(2); chk("wrapload_old", seg1, 7'b0110000);
    at_state(2); chk("wrapload_new", seg1, 7'b0000000);
    for (int k = 0; k < 20 && t % 16 != 3; k++) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (seg1 == 7'b1111001) seen++;
    end
    chk("last_load_wins", seen, 0);
    at_state(6); chk("last_load_seg", seg1, 7'b0100100);
    at_state(1);
    en = 0;
    repeat (6) @(negedge clk);
    chk("en_dark_an", an1, 4'hF);
    chk("en_dark_seg", seg1, 7'h7F);
    repeat (6) @(negedge clk);
    en = 1;
    at_state(10); chk("en_resume_an", an1, 4'b1011);
    do_load(16'h5555, 4'b1111);
    at_state(6);
    #3 rst = 1;
    #1 chk("async_rst_an", an1, 4'hF);
    chk("async_rst_seg", seg1, 7'h7F);
    chk("async_rst_dp", dp1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 0;
    at_state(2); chk("post_rst_an", an1, 4'b1110); chk("post_rst_seg", seg1, 7'b1000000);
    at_state(10); chk("post_rst_lost", seg1, 7'b1000000);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom % 8 == 0) begin
        load = 1;
        for (int n = 0; n < 4; n++) digits_in[4*n +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
        dp_in = 4'($urandom);
      end else load = 0;
      if ($urandom % 40 == 0) en = ~en;
      if ($urandom % 20 == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    load = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
